// File: rtl/fp_pkg.sv
// Shared float-normalisation types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/normalize_round_if.sv
// Handshake bundle between the adder stage, the normaliser and the consumer.
// Latency: n/a (wires only).
// Backpressure: inReady/outReady carry the valid-ready handshake both ways.
interface normalize_round_if;

    logic        inValid;
    logic        inReady;
    logic        signIn;
    logic [7:0]  exponentIn;
    logic [24:0] sumMantissa;
    logic        guardBit;
    logic        roundBit;
    logic        stickyBit;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    // Producer/consumer side: drives sums in, takes results out.
    modport master (
        output inValid, signIn, exponentIn, sumMantissa,
               guardBit, roundBit, stickyBit, outReady,
        input  inReady, outValid, result, overflow, underflow
    );

    // Normaliser side.
    modport slave (
        input  inValid, signIn, exponentIn, sumMantissa,
               guardBit, roundBit, stickyBit, outReady,
        output inReady, outValid, result, overflow, underflow
    );

endinterface

// File: rtl/round_nearest_even.sv
// Round-to-nearest-even increment decision and rounded mantissa.
// Latency: combinational.
// Backpressure: none.
module round_nearest_even
    import fp_pkg::*;
(
    input  logic [MANT_W:0]   mant,
    input  logic              g,
    input  logic              r,
    input  logic              s,
    output logic              inc,
    output logic [MANT_W+1:0] rounded
);

    // Round up above half, and on an exact half only when the lsb is odd.
    assign inc     = g & (r | s | mant[0]);
    assign rounded = {1'b0, mant} + {{(MANT_W+1){1'b0}}, inc};

endmodule

// File: rtl/normalize_round.sv
// Normalises a raw adder sum, rounds RNE and packs an IEEE-754 single.
// Latency: 2 clocks accept-to-outValid, plus 1 per left shift (max 25).
// Backpressure: one op in flight; inReady only in IDLE, result held until outReady.
module normalize_round
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    normalize_round_if.slave  bus
);

    state_t       state_q, state_nxt;
    logic         sign_q,  sign_nxt;
    logic [8:0]   exp_q,   exp_nxt;   // 9 bits so a carry past 254 is visible
    logic [23:0]  mant_q,  mant_nxt;  // bit 23 is the implicit one
    logic         g_q,     g_nxt;
    logic         r_q,     r_nxt;
    logic         s_q,     s_nxt;
    logic [31:0]  res_q,   res_nxt;
    logic         ovf_q,   ovf_nxt;
    logic         unf_q,   unf_nxt;

    logic         rnd_inc;
    logic [24:0]  rnd_mant;
    logic         rnd_carry;
    logic [8:0]   exp_rnd;
    logic [22:0]  frac_rnd;

    round_nearest_even u_rne (
        .mant    (mant_q),
        .g       (g_q),
        .r       (r_q),
        .s       (s_q),
        .inc     (rnd_inc),
        .rounded (rnd_mant)
    );

    // A carry out of rounding leaves 1.000..0, so dropping the low bit loses nothing.
    assign rnd_carry = rnd_inc & rnd_mant[24];
    assign exp_rnd   = exp_q + {8'd0, rnd_carry};
    assign frac_rnd  = rnd_carry ? rnd_mant[23:1] : rnd_mant[22:0];

    assign bus.inReady   = (state_q == IDLE);
    assign bus.outValid  = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 9'd0;
            mant_q  <= 24'd0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            res_q   <= 32'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sign_q  <= sign_nxt;
            exp_q   <= exp_nxt;
            mant_q  <= mant_nxt;
            g_q     <= g_nxt;
            r_q     <= r_nxt;
            s_q     <= s_nxt;
            res_q   <= res_nxt;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
        end
    end

    // Next-state and datapath update for accept, normalise, round and hand-off.
    always_comb begin
        state_nxt = state_q;
        sign_nxt  = sign_q;
        exp_nxt   = exp_q;
        mant_nxt  = mant_q;
        g_nxt     = g_q;
        r_nxt     = r_q;
        s_nxt     = s_q;
        res_nxt   = res_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;

        case (state_q)
            IDLE: begin
                if (bus.inValid) begin
                    sign_nxt  = bus.signIn;
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    state_nxt = NORM;
                    if (bus.sumMantissa[24]) begin
                        // Carry-out: fold the dropped bit into G/R/S.
                        mant_nxt = bus.sumMantissa[24:1];
                        g_nxt    = bus.sumMantissa[0];
                        r_nxt    = bus.guardBit;
                        s_nxt    = bus.roundBit | bus.stickyBit;
                        exp_nxt  = {1'b0, bus.exponentIn} + 9'd1;
                    end else begin
                        mant_nxt = bus.sumMantissa[23:0];
                        g_nxt    = bus.guardBit;
                        r_nxt    = bus.roundBit;
                        s_nxt    = bus.stickyBit;
                        exp_nxt  = {1'b0, bus.exponentIn};
                    end
                end
            end

            NORM: begin
                if ((mant_q == 24'd0) && !g_q && !r_q && !s_q) begin
                    res_nxt   = {sign_q, 31'd0};
                    state_nxt = DONE;
                end else if (exp_q == 9'd0) begin
                    // No denormals: anything that runs out of exponent flushes.
                    res_nxt   = {sign_q, 31'd0};
                    unf_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (mant_q[23]) begin
                    state_nxt = ROUND;
                end else begin
                    mant_nxt = {mant_q[22:0], g_q};
                    g_nxt    = r_q;
                    r_nxt    = 1'b0;
                    exp_nxt  = exp_q - 9'd1;
                end
            end

            ROUND: begin
                if (exp_rnd >= 9'(EXP_MAX)) begin
                    res_nxt = {sign_q, 8'hFF, 23'd0};
                    ovf_nxt = 1'b1;
                end else begin
                    res_nxt = {sign_q, exp_rnd[7:0], frac_rnd};
                end
                state_nxt = DONE;
            end

            DONE: begin
                if (bus.outReady) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_normalize_round.sv
// Directed-vector bench for normalize_round with hand-computed results.
// Checks result, flags and accept-to-outValid latency for each vector.
// Also exercises output backpressure, busy-time inValid and mid-operation reset.
module tb_normalize_round;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    normalize_round_if bus ();

    normalize_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, want);
        end
    endtask

    // Present one sum, measure latency, check outputs, optionally stall, then take it.
    task automatic run_op(input string tag, input logic sg, input logic [7:0] ex,
                          input logic [24:0] mt, input logic [2:0] grs,
                          input logic [31:0] want, input logic ovf, input logic unf,
                          input int lat_want, input int hold);
        int lat;
        @(negedge clk);
        check_eq({tag, "_rdy"}, 32'(bus.inReady), 32'd1);
        bus.signIn      = sg;
        bus.exponentIn  = ex;
        bus.sumMantissa = mt;
        bus.guardBit    = grs[2];
        bus.roundBit    = grs[1];
        bus.stickyBit   = grs[0];
        bus.inValid     = 1'b1;
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        lat = 0;
        while (bus.outValid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_vld"}, 32'(bus.outValid), 32'd1);
        if (bus.outValid !== 1'b1) return;
        check_eq({tag, "_lat"}, 32'(lat), 32'(lat_want));
        check_eq({tag, "_res"}, bus.result, want);
        check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
        check_eq({tag, "_unf"}, 32'(bus.underflow), 32'(unf));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            // A competing sum while busy must be ignored.
            bus.signIn      = 1'b1;
            bus.exponentIn  = 8'h10;
            bus.sumMantissa = 25'h1234567;
            bus.inValid     = 1'b1;
            @(posedge clk);
            #1;
            bus.inValid = 1'b0;
            check_eq({tag, "_hold_res"}, bus.result, want);
            check_eq({tag, "_hold_rdy"}, 32'(bus.inReady), 32'd0);
            check_eq({tag, "_hold_vld"}, 32'(bus.outValid), 32'd1);
        end
        @(negedge clk);
        bus.outReady = 1'b1;
        @(posedge clk);
        #1;
        bus.outReady = 1'b0;
        check_eq({tag, "_taken_vld"}, 32'(bus.outValid), 32'd0);
        check_eq({tag, "_taken_rdy"}, 32'(bus.inReady), 32'd1);
    endtask

    initial begin
        bus.inValid     = 1'b0;
        bus.signIn      = 1'b0;
        bus.exponentIn  = 8'd0;
        bus.sumMantissa = 25'd0;
        bus.guardBit    = 1'b0;
        bus.roundBit    = 1'b0;
        bus.stickyBit   = 1'b0;
        bus.outReady    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdy", 32'(bus.inReady), 32'd1);
        check_eq("rst_vld", 32'(bus.outValid), 32'd0);
        check_eq("rst_res", bus.result, 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_unf", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     tag        sign  exp     mantissa      GRS     result        ovf   unf   lat hold
        run_op("carry",   1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0,  2, 0);
        run_op("cancel",  1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 1'b0, 1'b0, 25, 0);
        run_op("tie_odd", 1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0,  2, 0);
        run_op("tie_evn", 1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 1'b0,  2, 0);
        run_op("abv_hlf", 1'b0, 8'd127, 25'h0800000, 3'b110, 32'h3F800001, 1'b0, 1'b0,  2, 0);
        run_op("rnd_cry", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 1'b0, 1'b0,  2, 0);
        run_op("exp_ovf", 1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 1'b1, 1'b0,  2, 0);
        run_op("neg_zero",1'b1, 8'd127, 25'h0000000, 3'b000, 32'h80000000, 1'b0, 1'b0,  1, 0);
        run_op("undflow", 1'b0, 8'd3,   25'h0000100, 3'b000, 32'h00000000, 1'b0, 1'b1,  4, 0);
        run_op("neg_12",  1'b1, 8'd130, 25'h0C00000, 3'b000, 32'hC1400000, 1'b0, 1'b0,  2, 0);
        run_op("shl_g",   1'b0, 8'd127, 25'h0400000, 3'b100, 32'h3F000001, 1'b0, 1'b0,  3, 0);
        run_op("cry_grs", 1'b0, 8'd127, 25'h1000003, 3'b100, 32'h40000002, 1'b0, 1'b0,  2, 0);
        run_op("bp_hold", 1'b1, 8'd128, 25'h0A00000, 3'b000, 32'hC0200000, 1'b0, 1'b0,  2, 5);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        bus.signIn      = 1'b0;
        bus.exponentIn  = 8'd127;
        bus.sumMantissa = 25'h0000001;
        bus.guardBit    = 1'b0;
        bus.roundBit    = 1'b0;
        bus.stickyBit   = 1'b0;
        bus.inValid     = 1'b1;
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_busy_rdy", 32'(bus.inReady), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", 32'(bus.outValid), 32'd0);
        check_eq("mid_rst_rdy", 32'(bus.inReady), 32'd1);
        check_eq("mid_rst_res", bus.result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_eq("post_rst_idle", 32'(bus.outValid), 32'd0);
        run_op("post_rst", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
